rect_fill_engine: RTL and testbench

//  Parametrised rectangle/shape raster engine feeding the VGA frame-buffer write port.

---
 rtl/rect_fill_engine.sv | 210 +++++++++++++++++++++
 tb/tb_rect_fill_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_engine.sv
// -----------------------------------------------------------------------------
// rect_fill_engine
//   Shape raster engine for the VGA frame-buffer write port. Takes one request
//   (bounding box, mode, colour) through a valid/ready handshake, then walks
//   every position of the box in row-major order, one position per unstalled
//   cycle. Each position raises plot_en only if it passes the mode test.
//
//   Ports
//     Clck, Reset              clock (posedge), synchronous active-low reset
//     req_valid / req_ready    request handshake (ready only while idle)
//     x_start, x_end           box columns, start inclusive / end exclusive
//     y_start, y_end           box rows,    start inclusive / end exclusive
//     mode                     00 FILL, 01 OUTLINE, 10 CIRCLE, 11 FILL
//     color_in                 colour applied to every plotted pixel
//     plot_stall               downstream busy: hold outputs and scan position
//     plot_x/plot_y/plot_color pixel position and colour (registered)
//     plot_en                  write strobe for the pixel outputs
//     busy                     high while scanning and in the done cycle
//     done                     one-cycle pulse after the last scan position
//
//   Build option
//     RECT_FILL_CIRCLE_EN      defined: mode 10 draws a disc inscribed in the
//                              box. Undefined: no multipliers, mode 10 = FILL.
// -----------------------------------------------------------------------------
module rect_fill_engine #(
    parameter int X_BITS     = 8,
    parameter int Y_BITS     = 7,
    parameter int COLOR_BITS = 3
) (
    input  logic                  Clck,
    input  logic                  Reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [X_BITS-1:0]     x_start,
    input  logic [X_BITS-1:0]     x_end,
    input  logic [Y_BITS-1:0]     y_start,
    input  logic [Y_BITS-1:0]     y_end,
    input  logic [1:0]            mode,
    input  logic [COLOR_BITS-1:0] color_in,
    input  logic                  plot_stall,
    output logic [X_BITS-1:0]     plot_x,
    output logic [Y_BITS-1:0]     plot_y,
    output logic [COLOR_BITS-1:0] plot_color,
    output logic                  plot_en,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

`ifdef RECT_FILL_CIRCLE_EN
    // Offsets from the box centre are kept in doubled coordinates so that
    // even-sized boxes have an integer centre.
    localparam int CW = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + 2;
    localparam int PW = 2 * CW;
`endif

    state_t                  state_q, state_d;
    logic [X_BITS-1:0]       xs_q, xs_d, xe_q, xe_d, x_q, x_d;
    logic [Y_BITS-1:0]       ys_q, ys_d, ye_q, ye_d, y_q, y_d;
    logic [1:0]              mode_q, mode_d;
    logic [COLOR_BITS-1:0]   color_q, color_d;
    logic                    en_q, en_d;

    logic                    req_empty;
    logic                    x_wrap;
    logic                    last_pos;

    // Mode test for one position against one box. Comparisons against the
    // exclusive ends are done as p+1 == end in a widened domain so xe-1 never
    // underflows.
    function automatic logic pass_test(
        input logic [X_BITS-1:0] px,
        input logic [Y_BITS-1:0] py,
        input logic [X_BITS-1:0] bxs,
        input logic [X_BITS-1:0] bxe,
        input logic [Y_BITS-1:0] bys,
        input logic [Y_BITS-1:0] bye,
        input logic [1:0]        md
    );
`ifdef RECT_FILL_CIRCLE_EN
        logic signed [CW-1:0] dx, dy;
        logic signed [PW-1:0] dxe, dye;
        logic [CW-1:0]        w, h, dmin;
        logic [PW-1:0]        r2, d2;
`endif
        logic result;
        result = 1'b1;
        if (md == 2'b01) begin
            result = (px == bxs) || (({1'b0, px} + 1'b1) == {1'b0, bxe}) ||
                     (py == bys) || (({1'b0, py} + 1'b1) == {1'b0, bye});
        end
`ifdef RECT_FILL_CIRCLE_EN
        else if (md == 2'b10) begin
            dx   = $signed((CW'(px) << 1) - (CW'(bxs) + CW'(bxe) - CW'(1)));
            dy   = $signed((CW'(py) << 1) - (CW'(bys) + CW'(bye) - CW'(1)));
            dxe  = PW'(dx);
            dye  = PW'(dy);
            r2   = $unsigned(dxe * dxe) + $unsigned(dye * dye);
            w    = CW'(bxe) - CW'(bxs);
            h    = CW'(bye) - CW'(bys);
            dmin = (w < h) ? w : h;
            d2   = PW'(dmin) * PW'(dmin);
            result = (r2 <= d2);
        end
`endif
        return result;
    endfunction

    assign req_empty = (x_end <= x_start) || (y_end <= y_start);
    assign x_wrap    = (({1'b0, x_q} + 1'b1) == {1'b0, xe_q});
    assign last_pos  = x_wrap && (({1'b0, y_q} + 1'b1) == {1'b0, ye_q});

    // State and datapath registers
    always_ff @(posedge Clck) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            xs_q    <= '0;
            xe_q    <= '0;
            ys_q    <= '0;
            ye_q    <= '0;
            mode_q  <= '0;
            color_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            xe_q    <= xe_d;
            ys_q    <= ys_d;
            ye_q    <= ye_d;
            mode_q  <= mode_d;
            color_q <= color_d;
            x_q     <= x_d;
            y_q     <= y_d;
            en_q    <= en_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = req_empty ? S_DONE : S_RUN;
            S_RUN:   if (!plot_stall && last_pos) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: latch the request, step the scan position and register the
    // mode test of the position that will be visible next cycle.
    always_comb begin
        xs_d    = xs_q;
        xe_d    = xe_q;
        ys_d    = ys_q;
        ye_d    = ye_q;
        mode_d  = mode_q;
        color_d = color_q;
        x_d     = x_q;
        y_d     = y_q;
        en_d    = en_q;
        case (state_q)
            S_IDLE: begin
                en_d = 1'b0;
                if (req_valid) begin
                    xs_d    = x_start;
                    xe_d    = x_end;
                    ys_d    = y_start;
                    ye_d    = y_end;
                    mode_d  = mode;
                    color_d = color_in;
                    x_d     = x_start;
                    y_d     = y_start;
                    en_d    = !req_empty &&
                              pass_test(x_start, y_start, x_start, x_end, y_start, y_end, mode);
                end
            end
            S_RUN: begin
                if (!plot_stall) begin
                    if (last_pos) begin
                        en_d = 1'b0;
                    end else begin
                        if (x_wrap) begin
                            x_d = xs_q;
                            y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                        en_d = pass_test(x_d, y_d, xs_q, xe_q, ys_q, ye_q, mode_q);
                    end
                end
            end
            default: en_d = 1'b0;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        busy       = (state_q == S_RUN) || (state_q == S_DONE);
        done       = (state_q == S_DONE);
        plot_x     = x_q;
        plot_y     = y_q;
        plot_en    = en_q;
        plot_color = color_q;
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// -----------------------------------------------------------------------------
// tb_rect_fill_engine
//   Drives directed and random shape requests into rect_fill_engine and
//   compares every cycle against a list of scan positions built up front from
//   the shape rules with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_rect_fill_engine;

    localparam int XB = 8;
    localparam int YB = 7;
    localparam int CB = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [XB-1:0] x_start, x_end;
    logic [YB-1:0] y_start, y_end;
    logic [1:0]    mode;
    logic [CB-1:0] color_in;
    logic          plot_stall;
    logic [XB-1:0] plot_x;
    logic [YB-1:0] plot_y;
    logic [CB-1:0] plot_color;
    logic          plot_en;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_ops    = 0;

    always #5 clk = ~clk;

    rect_fill_engine #(.X_BITS(XB), .Y_BITS(YB), .COLOR_BITS(CB)) dut (
        .Clck       (clk),
        .Reset      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .x_start    (x_start),
        .x_end      (x_end),
        .y_start    (y_start),
        .y_end      (y_end),
        .mode       (mode),
        .color_in   (color_in),
        .plot_stall (plot_stall),
        .plot_x     (plot_x),
        .plot_y     (plot_y),
        .plot_color (plot_color),
        .plot_en    (plot_en),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    // Shape membership straight from the geometric rules.
    function automatic bit model_pass(int x, int y, int xs, int xe, int ys, int ye, int md);
        int dx, dy, d;
        if (md == 1)
            return (x == xs) || (x == xe - 1) || (y == ys) || (y == ye - 1);
`ifdef RECT_FILL_CIRCLE_EN
        if (md == 2) begin
            dx = 2 * x - (xs + xe - 1);
            dy = 2 * y - (ys + ye - 1);
            d  = ((xe - xs) < (ye - ys)) ? (xe - xs) : (ye - ys);
            return (dx * dx + dy * dy) <= (d * d);
        end
`endif
        d = 0;
        return 1'b1;
    endfunction

    task automatic run_op(input int xs, input int xe, input int ys, input int ye,
                          input int md, input int col,
                          input int stall_at, input int stall_len, input bit rnd_stall,
                          output int plots);
        int  qx[$];
        int  qy[$];
        bit  qe[$];
        int  n, nst;
        bit  st;
        plots = 0;
        nst   = 0;
        if (xe > xs && ye > ys)
            for (int y = ys; y < ye; y++)
                for (int x = xs; x < xe; x++) begin
                    qx.push_back(x);
                    qy.push_back(y);
                    qe.push_back(model_pass(x, y, xs, xe, ys, ye, md));
                end
        n = qx.size();

        check("idle_ready", req_ready, 1);
        x_start    = xs[XB-1:0];
        x_end      = xe[XB-1:0];
        y_start    = ys[YB-1:0];
        y_end      = ye[YB-1:0];
        mode       = md[1:0];
        color_in   = col[CB-1:0];
        req_valid  = 1'b1;
        plot_stall = 1'b0;
        @(posedge clk); #1;
        // Garbage on the request bus while busy must be ignored.
        req_valid = 1'($urandom_range(0, 1));
        x_start   = XB'($urandom);
        x_end     = XB'($urandom);
        y_start   = YB'($urandom);
        y_end     = YB'($urandom);
        mode      = 2'($urandom);
        color_in  = CB'($urandom);

        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 64; k++) begin
                check("plot_x", plot_x, qx[i]);
                check("plot_y", plot_y, qy[i]);
                check("plot_en", plot_en, qe[i]);
                check("busy_run", busy, 1);
                check("ready_run", req_ready, 0);
                check("done_run", done, 0);
                if (qe[i]) check("plot_color", plot_color, col);
                st = rnd_stall ? (k < 3 && $urandom_range(0, 3) == 0)
                               : (i == stall_at && k < stall_len);
                plot_stall = st;
                if (st) nst++;
                if (!st && plot_en) plots++;
                @(posedge clk); #1;
                if (!st) break;
            end
        end
        plot_stall = 1'b0;
        check("done_pulse", done, 1);
        check("done_en", plot_en, 0);
        check("done_busy", busy, 1);
        check("done_ready", req_ready, 0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("post_ready", req_ready, 1);
        check("post_done", done, 0);
        check("post_busy", busy, 0);
        check("post_en", plot_en, 0);
        n_ops++;
        $display("op %0d mode %0d box x[%0d,%0d) y[%0d,%0d) color %0d positions %0d stalls %0d plots %0d",
                 n_ops, md, xs, xe, ys, ye, col, n, nst, plots);
    endtask

    initial begin
        int plots;
        int xs, xe, ys, ye;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        plot_stall = 1'b0;
        x_start    = '0;
        x_end      = '0;
        y_start    = '0;
        y_end      = '0;
        mode       = '0;
        color_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_en", plot_en, 0);
        check("rst_x", plot_x, 0);
        check("rst_y", plot_y, 0);
        check("rst_color", plot_color, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(4, 7, 2, 4, 0, 5, -1, 0, 1'b0, plots);
        check("fill_plots", plots, 6);
        run_op(0, 4, 0, 4, 1, 3, -1, 0, 1'b0, plots);
        check("outline_plots", plots, 12);
        run_op(0, 8, 0, 8, 2, 6, -1, 0, 1'b0, plots);
`ifndef RECT_FILL_CIRCLE_EN
        check("circle_off_plots", plots, 64);
`endif
        run_op(0, 4, 0, 1, 0, 7, 2, 3, 1'b0, plots);
        check("stall_plots", plots, 4);
        run_op(5, 5, 0, 3, 0, 2, -1, 0, 1'b0, plots);
        check("empty_plots", plots, 0);
        run_op(3, 3, 9, 2, 1, 2, -1, 0, 1'b0, plots);
        check("empty_y_plots", plots, 0);
        run_op(250, 255, 120, 127, 3, 4, -1, 0, 1'b1, plots);
        check("edge_mode3_plots", plots, 35);
        run_op(252, 255, 124, 127, 1, 1, -1, 0, 1'b0, plots);
        check("edge_outline_plots", plots, 8);

        // Reset in the middle of a 10x10 fill.
        x_start   = 8'd0;
        x_end     = 8'd10;
        y_start   = 7'd0;
        y_end     = 7'd10;
        mode      = 2'd0;
        color_in  = 3'd3;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (37) @(posedge clk);
        #1;
        check("mid_x", plot_x, 7);
        check("mid_y", plot_y, 3);
        check("mid_en", plot_en, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_en", plot_en, 0);
        check("abort_ready", req_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("op reset abort: 10x10 fill reset at pixel 37");

        for (int r = 0; r < 40; r++) begin
            xs = $urandom_range(0, 254);
            xe = xs + $urandom_range(0, 9);
            if (xe > 255) xe = 255;
            ys = $urandom_range(0, 126);
            ye = ys + $urandom_range(0, 8);
            if (ye > 127) ye = 127;
            if ($urandom_range(0, 9) == 0) xe = xs - (xs > 0 ? 1 : 0);
            run_op(xs, xe, ys, ye, $urandom_range(0, 3), $urandom_range(0, 7),
                   -1, 0, 1'b1, plots);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
